// File: rtl/adma_dm_aw_sched_if.sv
// adma_dm_aw_sched_if: request, transaction-info and AXI AW bundle for the write scheduler
// Ports (master = scheduler side):
//   chn_req_vld/addr/len in, chn_req_rdy out  per-channel burst requests
//   atx_id out, atx_done in                   per-channel AWID and B completions
//   atx_chn_id/atx_awid/atx_vld out, atx_rdy  transaction registration to the B handler
//   m_aw*_o out, m_awready_i in               AXI AW channel
//   chn_ostd_busy, sched_idle out             status
interface adma_dm_aw_sched_if #(
    parameter int DMA_CHN_NUM   = 4,
    parameter int MST_ID_W      = 5,
    parameter int ADDR_W        = 32,
    parameter int LEN_W         = 8,
    parameter int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
);
    logic [DMA_CHN_NUM-1:0]   chn_req_vld, chn_req_rdy, atx_done, chn_ostd_busy;
    logic [ADDR_W-1:0]        chn_req_addr [DMA_CHN_NUM];
    logic [LEN_W-1:0]         chn_req_len  [DMA_CHN_NUM];
    logic [MST_ID_W-1:0]      atx_id       [DMA_CHN_NUM];
    logic [DMA_CHN_NUM_W-1:0] atx_chn_id;
    logic [MST_ID_W-1:0]      atx_awid, m_awid_o;
    logic [ADDR_W-1:0]        m_awaddr_o;
    logic [LEN_W-1:0]         m_awlen_o;
    logic                     atx_vld, atx_rdy, m_awvalid_o, m_awready_i, sched_idle;
    modport master (
        input  chn_req_vld, chn_req_addr, chn_req_len, atx_done, atx_rdy, m_awready_i,
        output chn_req_rdy, atx_id, atx_chn_id, atx_awid, atx_vld,
               m_awid_o, m_awaddr_o, m_awlen_o, m_awvalid_o, chn_ostd_busy, sched_idle
    );
    modport slave (
        output chn_req_vld, chn_req_addr, chn_req_len, atx_done, atx_rdy, m_awready_i,
        input  chn_req_rdy, atx_id, atx_chn_id, atx_awid, atx_vld,
               m_awid_o, m_awaddr_o, m_awlen_o, m_awvalid_o, chn_ostd_busy, sched_idle
    );
endinterface

// File: rtl/adma_dm_aw_sched.sv
// adma_dm_aw_sched: round-robin write-burst scheduler with per-channel and global outstanding limits
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   sif    adma_dm_aw_sched_if.master: requests, AXI AW, transaction info, completions, status
module adma_dm_aw_sched #(
    parameter int DMA_CHN_NUM   = 4,
    parameter int MST_ID_W      = 5,
    parameter int ADDR_W        = 32,
    parameter int LEN_W         = 8,
    parameter int ATX_NUM_OSTD  = DMA_CHN_NUM,
    parameter int CHN_OSTD_MAX  = 2,
    parameter int ID_BASE       = 0,
    parameter int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1,
    parameter int OSTD_W        = $clog2(ATX_NUM_OSTD + 1)
) (
    input logic                clk,
    input logic                rst_n,
    adma_dm_aw_sched_if.master sif
);
    localparam int CNT_W = $clog2(CHN_OSTD_MAX + 1);
    localparam logic [CNT_W-1:0]  CHN_MAX = CNT_W'(CHN_OSTD_MAX);
    localparam logic [OSTD_W-1:0] GLB_MAX = OSTD_W'(ATX_NUM_OSTD);

    typedef enum logic {ARB, ISSUE} state_t;
    state_t                   r_state, w_state_nxt;
    logic                     r_aw_pend, r_atx_pend, w_aw_pend_nxt, w_atx_pend_nxt;
    logic [DMA_CHN_NUM_W-1:0] r_last_gnt, r_chn, w_win;
    logic [MST_ID_W-1:0]      r_awid;
    logic [ADDR_W-1:0]        r_addr;
    logic [LEN_W-1:0]         r_len;
    logic [CNT_W-1:0]         r_chn_cnt [DMA_CHN_NUM];
    logic [OSTD_W-1:0]        r_glb_cnt, w_done_num;
    logic [DMA_CHN_NUM-1:0]   w_elig, w_dec;
    logic                     w_found, w_grant;

    // Search starts one past the last winner so every requester is served in turn.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_done_num = '0;
        for (int k = 1; k <= DMA_CHN_NUM; k++) begin
            if (!w_found && w_elig[DMA_CHN_NUM_W'((int'(r_last_gnt) + k) % DMA_CHN_NUM)]) begin
                w_found = 1'b1;
                w_win   = DMA_CHN_NUM_W'((int'(r_last_gnt) + k) % DMA_CHN_NUM);
            end
        end
        for (int k = 0; k < DMA_CHN_NUM; k++)
            w_done_num = w_done_num + OSTD_W'(w_dec[k]);
    end

    assign w_grant = (r_state == ARB) && w_found;

    for (genvar i = 0; i < DMA_CHN_NUM; i++) begin : g_chn
        assign w_elig[i]            = sif.chn_req_vld[i] && (r_chn_cnt[i] < CHN_MAX) && (r_glb_cnt < GLB_MAX);
        // Completions on an empty channel are dropped so counters never wrap.
        assign w_dec[i]             = sif.atx_done[i] && (r_chn_cnt[i] != '0);
        assign sif.chn_ostd_busy[i] = r_chn_cnt[i] != '0;
        assign sif.chn_req_rdy[i]   = w_grant && (w_win == DMA_CHN_NUM_W'(i));
        assign sif.atx_id[i]        = MST_ID_W'(ID_BASE + i);
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) r_chn_cnt[i] <= '0;
            else        r_chn_cnt[i] <= r_chn_cnt[i] + CNT_W'(sif.chn_req_rdy[i]) - CNT_W'(w_dec[i]);
    end

    // Leave ISSUE once both the AW and the info handshakes have completed.
    always_comb begin
        w_aw_pend_nxt  = r_aw_pend && !sif.m_awready_i;
        w_atx_pend_nxt = r_atx_pend && !sif.atx_rdy;
        w_state_nxt    = r_state;
        if (w_grant) begin
            w_state_nxt    = ISSUE;
            w_aw_pend_nxt  = 1'b1;
            w_atx_pend_nxt = 1'b1;
        end else if (r_state == ISSUE && !w_aw_pend_nxt && !w_atx_pend_nxt) begin
            w_state_nxt = ARB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ARB;
            r_aw_pend  <= 1'b0;
            r_atx_pend <= 1'b0;
            r_last_gnt <= DMA_CHN_NUM_W'(DMA_CHN_NUM - 1);
            r_chn      <= '0;
            r_awid     <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_glb_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_aw_pend  <= w_aw_pend_nxt;
            r_atx_pend <= w_atx_pend_nxt;
            r_glb_cnt  <= r_glb_cnt + OSTD_W'(w_grant) - w_done_num;
            if (w_grant) begin
                r_last_gnt <= w_win;
                r_chn      <= w_win;
                r_awid     <= MST_ID_W'(ID_BASE + int'(w_win));
                r_addr     <= sif.chn_req_addr[w_win];
                r_len      <= sif.chn_req_len[w_win];
            end
        end
    end

    assign sif.m_awvalid_o = r_aw_pend;
    assign sif.atx_vld     = r_atx_pend;
    assign sif.m_awid_o    = r_awid;
    assign sif.atx_awid    = r_awid;
    assign sif.m_awaddr_o  = r_addr;
    assign sif.m_awlen_o   = r_len;
    assign sif.atx_chn_id  = r_chn;
    assign sif.sched_idle  = (r_state == ARB) && (r_glb_cnt == '0);
endmodule

// File: tb/tb_adma_dm_aw_sched.sv
// tb_adma_dm_aw_sched: directed and randomized checks of the write scheduler against a transaction-level model
module tb_adma_dm_aw_sched;
    localparam int N = 4;
    localparam int W = 2;
    localparam int CMAX = 2;
    localparam int GMAX = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adma_dm_aw_sched_if #(.DMA_CHN_NUM(N), .MST_ID_W(5), .ADDR_W(32), .LEN_W(8)) sif();
    adma_dm_aw_sched #(
        .DMA_CHN_NUM(N), .MST_ID_W(5), .ADDR_W(32), .LEN_W(8),
        .ATX_NUM_OSTD(GMAX), .CHN_OSTD_MAX(CMAX), .ID_BASE(0)
    ) dut (.clk(clk), .rst_n(rst_n), .sif(sif));

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Transaction-level model: outstanding counts, last winner, one in-flight transaction.
    int          m_cnt [N];
    int          m_glb, m_last, m_chn;
    bit          m_iss, m_aw, m_at;
    logic [31:0] m_addr;
    logic [7:0]  m_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_glb = 0; m_last = N - 1; m_chn = 0;
        m_iss = 0; m_aw = 0; m_at = 0; m_addr = '0; m_len = '0;
    endtask

    function automatic logic [N-1:0] model_busy();
        logic [N-1:0] b = '0;
        for (int i = 0; i < N; i++) b[W'(i)] = m_cnt[i] > 0;
        return b;
    endfunction

    // One clock cycle: predict, compare mid-cycle, advance the model on the edge.
    task automatic step();
        int w = 0;
        bit g = 0;
        logic [N-1:0] v, d, rdy;
        v = sif.chn_req_vld;
        if (!m_iss)
            for (int k = 1; k <= N; k++) begin
                int c = (m_last + k) % N;
                if (!g && v[W'(c)] && m_cnt[c] < CMAX && m_glb < GMAX) begin g = 1; w = c; end
            end
        rdy = g ? N'(1 << w) : '0;
        #2;
        chk("req_rdy", 32'(sif.chn_req_rdy), 32'(rdy));
        chk("awvalid", 32'(sif.m_awvalid_o), 32'(m_aw));
        chk("atx_vld", 32'(sif.atx_vld), 32'(m_at));
        chk("awid", 32'(sif.m_awid_o), 32'(m_chn));
        chk("atx_awid", 32'(sif.atx_awid), 32'(m_chn));
        chk("atx_chn_id", 32'(sif.atx_chn_id), 32'(m_chn));
        chk("awaddr", sif.m_awaddr_o, m_addr);
        chk("awlen", 32'(sif.m_awlen_o), 32'(m_len));
        chk("ostd_busy", 32'(sif.chn_ostd_busy), 32'(model_busy()));
        chk("sched_idle", 32'(sif.sched_idle), 32'(!m_iss && m_glb == 0));
        @(posedge clk);
        #1;
        d = '0;
        for (int i = 0; i < N; i++) d[W'(i)] = sif.atx_done[W'(i)] && m_cnt[i] > 0;
        if (g) begin
            m_cnt[w]++; m_glb++; m_last = w;
            m_chn = w; m_addr = sif.chn_req_addr[W'(w)]; m_len = sif.chn_req_len[W'(w)];
            m_iss = 1; m_aw = 1; m_at = 1;
        end else if (m_iss) begin
            if (sif.m_awready_i) m_aw = 0;
            if (sif.atx_rdy) m_at = 0;
            if (!m_aw && !m_at) m_iss = 0;
        end
        for (int i = 0; i < N; i++)
            if (d[W'(i)]) begin m_cnt[i]--; m_glb--; end
    endtask

    task automatic drain();
        sif.chn_req_vld = '0; sif.m_awready_i = 1'b1; sif.atx_rdy = 1'b1; sif.atx_done = '1;
        repeat (4) step();
        sif.atx_done = '0;
    endtask

    initial begin
        int ngr;
        sif.chn_req_vld = '0; sif.atx_done = '0; sif.m_awready_i = 1'b0; sif.atx_rdy = 1'b0;
        for (int i = 0; i < N; i++) begin sif.chn_req_addr[W'(i)] = '0; sif.chn_req_len[W'(i)] = '0; end
        model_reset();
        #12;
        chk("rst_awvalid", 32'(sif.m_awvalid_o), 32'd0);
        chk("rst_atx_vld", 32'(sif.atx_vld), 32'd0);
        chk("rst_busy", 32'(sif.chn_ostd_busy), 32'd0);
        chk("rst_idle", 32'(sif.sched_idle), 32'd1);
        for (int i = 0; i < N; i++) chk("atx_id", 32'(sif.atx_id[W'(i)]), 32'(i));
        @(posedge clk); #1; rst_n = 1'b1;
        step();
        // single request on channel 2
        sif.chn_req_addr[2] = 32'h1000; sif.chn_req_len[2] = 8'd7;
        sif.chn_req_vld = 4'b0100; sif.m_awready_i = 1'b1; sif.atx_rdy = 1'b1;
        #1; chk("single_rdy", 32'(sif.chn_req_rdy), 32'h4);
        step();
        sif.chn_req_vld = '0;
        chk("single_awid", 32'(sif.m_awid_o), 32'd2);
        chk("single_addr", sif.m_awaddr_o, 32'h1000);
        chk("single_len", 32'(sif.m_awlen_o), 32'd7);
        chk("single_chn", 32'(sif.atx_chn_id), 32'd2);
        repeat (3) step();
        chk("single_busy", 32'(sif.chn_ostd_busy), 32'h4);
        sif.atx_done = 4'b0100; step();
        sif.atx_done = '0; step();
        chk("single_idle", 32'(sif.sched_idle), 32'd1);
        // round-robin with prompt completions; last winner was channel 2
        sif.chn_req_vld = '1;
        for (int k = 0; k < 8; k++) begin
            sif.atx_done = model_busy();
            #1; chk("rr_order", 32'(sif.chn_req_rdy), 32'(1 << ((3 + k) % N)));
            step();
            sif.atx_done = model_busy();
            step();
        end
        drain();
        // per-channel limit
        sif.chn_req_vld = 4'b0010;
        repeat (8) step();
        #1; chk("chn_limit_stall", 32'(sif.chn_req_rdy), 32'd0);
        sif.atx_done = 4'b0010; step();
        sif.atx_done = '0;
        #1; chk("chn_limit_regrant", 32'(sif.chn_req_rdy), 32'h2);
        step();
        drain();
        // global limit
        sif.chn_req_vld = '1; ngr = 0;
        repeat (12) begin
            #1; if (sif.chn_req_rdy != '0) ngr++;
            step();
        end
        chk("glb_grants", 32'(ngr), 32'd4);
        chk("glb_stall", 32'(sif.chn_req_rdy), 32'd0);
        chk("glb_busy", 32'(sif.chn_ostd_busy), 32'hF);
        drain();
        // split handshake: AW at T+1, info at T+4
        sif.chn_req_vld = 4'b0001; sif.m_awready_i = 1'b1; sif.atx_rdy = 1'b0;
        step(); step();
        chk("split_aw_low", 32'(sif.m_awvalid_o), 32'd0);
        chk("split_atx_high", 32'(sif.atx_vld), 32'd1);
        step(); step();
        sif.atx_rdy = 1'b1; step();
        #1; chk("split_regrant", 32'(sif.chn_req_rdy), 32'h1);
        step();
        drain();
        // randomized traffic, including completions on idle channels
        repeat (400) begin
            sif.chn_req_vld = N'($urandom);
            for (int i = 0; i < N; i++) begin
                sif.chn_req_addr[W'(i)] = $urandom;
                sif.chn_req_len[W'(i)] = 8'($urandom);
            end
            sif.m_awready_i = $urandom_range(0, 9) < 7;
            sif.atx_rdy = $urandom_range(0, 9) < 7;
            sif.atx_done = N'($urandom) & N'($urandom);
            step();
        end
        // reset while a transaction is being issued
        drain();
        sif.chn_req_vld = '1; sif.m_awready_i = 1'b0; sif.atx_rdy = 1'b0;
        step(); step();
        chk("pre_rst_awvalid", 32'(sif.m_awvalid_o), 32'd1);
        #2; rst_n = 1'b0; #1;
        chk("mid_rst_awvalid", 32'(sif.m_awvalid_o), 32'd0);
        chk("mid_rst_atx_vld", 32'(sif.atx_vld), 32'd0);
        chk("mid_rst_busy", 32'(sif.chn_ostd_busy), 32'd0);
        chk("mid_rst_idle", 32'(sif.sched_idle), 32'd1);
        model_reset();
        sif.chn_req_vld = '0;
        @(posedge clk); #1; rst_n = 1'b1;
        sif.chn_req_vld = 4'b1000; sif.m_awready_i = 1'b1; sif.atx_rdy = 1'b1;
        repeat (4) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
